// File: rtl/hub75_frame_loader.sv
// Frame loader for the HUB75 driver: syncs to start-of-frame, fills the line buffer
// one row at a time, commits rows to the back buffer and requests a frame swap at the end.
module hub75_frame_loader #(
  parameter int N_BANKS     = 2,
  parameter int N_ROWS      = 32,
  parameter int N_COLS      = 64,
  parameter int N_CHANS     = 3,
  parameter int N_PLANES    = 8,
  parameter int LOG_N_BANKS = $clog2(N_BANKS),
  parameter int LOG_N_ROWS  = $clog2(N_ROWS),
  parameter int LOG_N_COLS  = $clog2(N_COLS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CHANS*N_PLANES-1:0]   in_data,
  input  logic                          in_sof,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [LOG_N_BANKS-1:0]        fbw_bank_addr,
  output logic [LOG_N_ROWS-1:0]         fbw_row_addr,
  output logic                          fbw_row_store,
  input  logic                          fbw_row_rdy,
  output logic                          fbw_row_swap,
  output logic [N_CHANS*N_PLANES-1:0]   fbw_data,
  output logic [LOG_N_COLS-1:0]         fbw_col_addr,
  output logic                          fbw_wren,
  output logic                          frame_swap,
  input  logic                          frame_rdy,
  output logic                          stat_frame_done,
  output logic                          stat_sof_err
);

  localparam int DW = N_CHANS * N_PLANES;
  localparam int RW = LOG_N_BANKS + LOG_N_ROWS;
  localparam int unsigned LAST_COL = N_COLS - 1;
  localparam int unsigned LAST_ROW = N_BANKS * N_ROWS - 1;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_FILL,
    ST_COMMIT,
    ST_FLUSH,
    ST_SWAP,
    ST_SWAP_WAIT
  } state_e;

  state_e                  state_q;
  logic [LOG_N_COLS-1:0]   col_q;
  logic [RW-1:0]           r_q;
  logic [1:0]              guard_q;
  logic                    skip_q;

  logic [LOG_N_BANKS-1:0]  bank_addr_q;
  logic [LOG_N_ROWS-1:0]   row_addr_q;
  logic                    row_store_q;
  logic                    row_swap_q;
  logic [DW-1:0]           data_q;
  logic [LOG_N_COLS-1:0]   col_addr_q;
  logic                    wren_q;
  logic                    frame_swap_q;
  logic                    frame_done_q;
  logic                    sof_err_q;

  logic last_col_d;
  logic last_row_d;
  logic rdy_ok_d;

  assign last_col_d = (col_q == LOG_N_COLS'(LAST_COL));
  assign last_row_d = (r_q == RW'(LAST_ROW));
  // The store engine's ready lags our store pulse, so it is masked for two cycles.
  assign rdy_ok_d   = fbw_row_rdy && (guard_q == 2'd0);

  assign in_ready = ~rst & ((state_q == ST_SYNC) | (state_q == ST_FILL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_SYNC;
      col_q        <= '0;
      r_q          <= '0;
      guard_q      <= '0;
      skip_q       <= 1'b0;
      bank_addr_q  <= '0;
      row_addr_q   <= '0;
      row_store_q  <= 1'b0;
      row_swap_q   <= 1'b0;
      data_q       <= '0;
      col_addr_q   <= '0;
      wren_q       <= 1'b0;
      frame_swap_q <= 1'b0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
    end else begin
      row_store_q  <= 1'b0;
      row_swap_q   <= 1'b0;
      wren_q       <= 1'b0;
      frame_swap_q <= 1'b0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
      if (guard_q != 2'd0) guard_q <= guard_q - 2'd1;

      case (state_q)
        ST_SYNC: begin
          if (in_valid && in_sof) begin
            wren_q     <= 1'b1;
            data_q     <= in_data;
            col_addr_q <= '0;
            col_q      <= LOG_N_COLS'(1);
            r_q        <= '0;
            state_q    <= ST_FILL;
          end
        end

        ST_FILL: begin
          if (in_valid) begin
            wren_q <= 1'b1;
            data_q <= in_data;
            if (in_sof && ((col_q != '0) || (r_q != '0))) begin
              // Resync: partial row dropped, this pixel restarts the frame.
              sof_err_q  <= 1'b1;
              col_addr_q <= '0;
              col_q      <= LOG_N_COLS'(1);
              r_q        <= '0;
            end else begin
              col_addr_q <= col_q;
              if (last_col_d) begin
                col_q   <= '0;
                state_q <= ST_COMMIT;
              end else begin
                col_q <= col_q + 1'b1;
              end
            end
          end
        end

        ST_COMMIT: begin
          if (rdy_ok_d) begin
            row_store_q <= 1'b1;
            row_swap_q  <= 1'b1;
            bank_addr_q <= r_q[RW-1 -: LOG_N_BANKS];
            row_addr_q  <= r_q[LOG_N_ROWS-1:0];
            guard_q     <= 2'd2;
            if (last_row_d) begin
              r_q     <= '0;
              state_q <= ST_FLUSH;
            end else begin
              r_q     <= r_q + 1'b1;
              state_q <= ST_FILL;
            end
          end
        end

        ST_FLUSH: begin
          if (rdy_ok_d) state_q <= ST_SWAP;
        end

        ST_SWAP: begin
          if (frame_rdy) begin
            frame_swap_q <= 1'b1;
            skip_q       <= 1'b1;
            state_q      <= ST_SWAP_WAIT;
          end
        end

        ST_SWAP_WAIT: begin
          if (skip_q) begin
            skip_q <= 1'b0;
          end else if (frame_rdy) begin
            frame_done_q <= 1'b1;
            state_q      <= ST_SYNC;
          end
        end

        default: state_q <= ST_SYNC;
      endcase
    end
  end

  assign fbw_bank_addr   = bank_addr_q;
  assign fbw_row_addr    = row_addr_q;
  assign fbw_row_store   = row_store_q;
  assign fbw_row_swap    = row_swap_q;
  assign fbw_data        = data_q;
  assign fbw_col_addr    = col_addr_q;
  assign fbw_wren        = wren_q;
  assign frame_swap      = frame_swap_q;
  assign stat_frame_done = frame_done_q;
  assign stat_sof_err    = sof_err_q;

endmodule

// File: tb/tb_hub75_frame_loader.sv
// Scoreboard bench for hub75_frame_loader on a 2x4x8 panel geometry.
module tb_hub75_frame_loader;

  localparam int NB = 2;
  localparam int NR = 4;
  localparam int NC = 8;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_sof;
  logic          in_valid;
  logic          in_ready;
  logic [0:0]    fbw_bank_addr;
  logic [1:0]    fbw_row_addr;
  logic          fbw_row_store;
  logic          fbw_row_rdy;
  logic          fbw_row_swap;
  logic [DW-1:0] fbw_data;
  logic [2:0]    fbw_col_addr;
  logic          fbw_wren;
  logic          frame_swap;
  logic          frame_rdy;
  logic          stat_frame_done;
  logic          stat_sof_err;

  always #5 clk = ~clk;

  hub75_frame_loader #(
    .N_BANKS (NB),
    .N_ROWS  (NR),
    .N_COLS  (NC),
    .N_CHANS (3),
    .N_PLANES(8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_sof         (in_sof),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .fbw_bank_addr  (fbw_bank_addr),
    .fbw_row_addr   (fbw_row_addr),
    .fbw_row_store  (fbw_row_store),
    .fbw_row_rdy    (fbw_row_rdy),
    .fbw_row_swap   (fbw_row_swap),
    .fbw_data       (fbw_data),
    .fbw_col_addr   (fbw_col_addr),
    .fbw_wren       (fbw_wren),
    .frame_swap     (frame_swap),
    .frame_rdy      (frame_rdy),
    .stat_frame_done(stat_frame_done),
    .stat_sof_err   (stat_sof_err)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned swap_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned err_cnt  = 0;
  int unsigned store_cnt = 0;

  logic [26:0] wr_q[$];
  logic [2:0]  st_q[$];
  logic [26:0] exp_wr;
  logic [2:0]  exp_st;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (fbw_wren) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", 32'(fbw_wren), 32'd0);
        end else begin
          exp_wr = wr_q.pop_front();
          check("write_col_data", 32'({fbw_col_addr, fbw_data}), 32'(exp_wr));
        end
      end
      if (fbw_row_store || fbw_row_swap) begin
        check("row_swap_with_store", 32'(fbw_row_swap), 32'(fbw_row_store));
        store_cnt++;
        if (st_q.size() == 0) begin
          check("unexpected_store", 32'(fbw_row_store), 32'd0);
        end else begin
          exp_st = st_q.pop_front();
          check("store_bank_row", 32'({fbw_bank_addr, fbw_row_addr}), 32'(exp_st));
        end
      end
      if (frame_swap)      swap_cnt++;
      if (stat_frame_done) done_cnt++;
      if (stat_sof_err)    err_cnt++;
    end
  end

  // Expectation for pixel idx within a frame: write at idx%NC; last column commits row idx/NC.
  task automatic expect_px(input int unsigned idx, input logic [DW-1:0] d);
    int unsigned r;
    wr_q.push_back({3'(idx % NC), d});
    if (idx % NC == NC - 1) begin
      r = idx / NC;
      st_q.push_back({1'(r / NR), 2'(r % NR)});
    end
  endtask

  task automatic send_px(input logic [DW-1:0] d, input logic sof);
    int unsigned w = 0;
    @(negedge clk);
    in_data  = d;
    in_sof   = sof;
    in_valid = 1'b1;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    else @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] base);
    for (int unsigned i = 0; i < NB*NR*NC; i++) begin
      expect_px(i, base + DW'(i));
      send_px(base + DW'(i), i == 0);
    end
  endtask

  task automatic wait_done(input int unsigned target);
    int unsigned w = 0;
    while (done_cnt < target && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("frame_done_count", done_cnt, target);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, 32'({fbw_bank_addr, fbw_row_addr, fbw_row_store, fbw_row_swap,
                               fbw_col_addr, fbw_wren, frame_swap, stat_frame_done,
                               stat_sof_err, in_ready}), 32'd0);
    check({tag, "_data"}, 32'(fbw_data), 32'd0);
  endtask

  initial begin
    int unsigned s0, e0, st0;
    rst         = 1'b1;
    in_data     = '0;
    in_sof      = 1'b0;
    in_valid    = 1'b0;
    fbw_row_rdy = 1'b1;
    frame_rdy   = 1'b1;

    #1;
    check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Clean frame
    send_frame(24'h000000);
    wait_done(1);
    check("clean_swap_count", swap_cnt, 32'd1);
    check("clean_store_count", store_cnt, 32'd8);
    check("clean_wr_drained", 32'(wr_q.size()), 32'd0);

    // Pre-sync garbage then a clean frame
    for (int unsigned i = 0; i < 5; i++) send_px(24'h000100 + DW'(i), 1'b0);
    send_frame(24'h001000);
    wait_done(2);
    check("garbage_swap_count", swap_cnt, 32'd2);
    check("garbage_store_count", store_cnt, 32'd16);
    check("garbage_wr_drained", 32'(wr_q.size()), 32'd0);

    // Back-pressure at the end of row 2
    for (int unsigned i = 0; i < NB*NR*NC; i++) begin
      expect_px(i, 24'h002000 + DW'(i));
      if (i == 23) fbw_row_rdy = 1'b0;
      send_px(24'h002000 + DW'(i), i == 0);
      if (i == 23) begin
        st0 = store_cnt;
        for (int unsigned k = 0; k < 10; k++) begin
          @(negedge clk);
          check("bp_in_ready_low", 32'(in_ready), 32'd0);
          check("bp_no_store", 32'(fbw_row_store), 32'd0);
        end
        fbw_row_rdy = 1'b1;
        @(negedge clk);
        check("bp_store_fires", 32'(fbw_row_store), 32'd1);
        check("bp_store_row", 32'(fbw_row_addr), 32'd2);
        check("bp_in_ready_back", 32'(in_ready), 32'd1);
      end
    end
    wait_done(3);
    check("bp_wr_drained", 32'(wr_q.size()), 32'd0);

    // Mid-frame sof at pixel 20 (row 2, col 4)
    e0 = err_cnt;
    for (int unsigned i = 0; i < 20; i++) begin
      expect_px(i, 24'h003000 + DW'(i));
      send_px(24'h003000 + DW'(i), i == 0);
    end
    for (int unsigned k = 0; k < NB*NR*NC; k++) begin
      expect_px(k, 24'h003014 + DW'(k));
      send_px(24'h003014 + DW'(k), k == 0);
      if (k == 0) begin
        @(negedge clk);
        check("sof_err_pulse", 32'(stat_sof_err), 32'd1);
      end
    end
    wait_done(4);
    check("sof_err_count", err_cnt, e0 + 1);
    check("sof_st_drained", 32'(st_q.size()), 32'd0);

    // Swap stall, then a dropped frame_rdy while waiting for swap completion
    s0 = swap_cnt;
    frame_rdy = 1'b0;
    send_frame(24'h004000);
    repeat (20) begin
      @(negedge clk);
      check("stall_in_ready_low", 32'(in_ready), 32'd0);
    end
    check("stall_no_swap", swap_cnt, s0);
    frame_rdy = 1'b1;
    for (int unsigned w = 0; w < 50 && swap_cnt == s0; w++) @(negedge clk);
    frame_rdy = 1'b0;
    check("stall_swap_issued", swap_cnt, s0 + 1);
    repeat (5) begin
      @(negedge clk);
      check("swap_wait_in_ready_low", 32'(in_ready), 32'd0);
    end
    check("swap_wait_no_done", done_cnt, 32'd4);
    frame_rdy = 1'b1;
    wait_done(5);
    #1;
    check("stall_in_ready_after_done", 32'(in_ready), 32'd1);

    // Async reset in the middle of row 3
    for (int unsigned i = 0; i < 28; i++) begin
      expect_px(i, 24'h005000 + DW'(i));
      send_px(24'h005000 + DW'(i), i == 0);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    check("rst_wr_drained", 32'(wr_q.size()), 32'd0);
    check("rst_st_drained", 32'(st_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready_after", 32'(in_ready), 32'd1);
    st0 = store_cnt;
    repeat (5) @(negedge clk);
    check("rst_no_stray_store", store_cnt, st0);
    send_frame(24'h006000);
    wait_done(6);
    check("final_wr_drained", 32'(wr_q.size()), 32'd0);
    check("final_st_drained", 32'(st_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/hub75_frame_loader.md
# hub75_frame_loader

Upstream feeder for the HUB75 panel driver's frame-buffer write port. Accepts a row-major pixel stream with start-of-frame marking and writes each panel row into the line buffer. It then commits each full row to the back frame buffer at the correct bank/row address. After the last row it requests a frame swap and waits for it to complete before syncing to the next frame.

## Interface
Parameters:
- N_BANKS, 2, parallel readout banks
- N_ROWS, 32, rows per bank (power of 2)
- N_COLS, 64, columns
- N_CHANS, 3, colour channels
- N_PLANES, 8, bits per channel
- LOG_N_BANKS / LOG_N_ROWS / LOG_N_COLS, $clog2 of the above, auto-set

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  clock
- rst  in  1  async active-high reset
- in_data  in  N_CHANS*N_PLANES  pixel, channel 0 in LSBs
- in_sof  in  1  marks first pixel of a frame
- in_valid  in  1  pixel valid
- in_ready  out  1  pixel accepted when in_valid & in_ready
- fbw_bank_addr  out  LOG_N_BANKS  bank of committed row
- fbw_row_addr  out  LOG_N_ROWS  row of committed row
- fbw_row_store  out  1  one-cycle commit pulse
- fbw_row_rdy  in  1  store engine idle
- fbw_row_swap  out  1  one-cycle line-buffer swap pulse
- fbw_data  out  N_CHANS*N_PLANES  line-buffer write data
- fbw_col_addr  out  LOG_N_COLS  line-buffer write column
- fbw_wren  out  1  line-buffer write enable
- frame_swap  out  1  one-cycle frame swap request
- frame_rdy  in  1  no swap pending
- stat_frame_done  out  1  pulse: frame swapped
- stat_sof_err  out  1  pulse: in_sof arrived mid-frame

## Operation
- Frame = N_BANKS*N_ROWS rows × N_COLS pixels, row-major. Global row index r maps to bank = r / N_ROWS (upper bits) and row = r % N_ROWS (lower bits).
- **SYNC:** in_ready=1. Pixels without in_sof are consumed and discarded. A pixel with in_sof is written as column 0 of r=0, and the FSM moves to FILL.
- **FILL:** in_ready=1. Each accepted pixel is written at the current column, and the column increments. The pixel at col N_COLS-1 moves the FSM to COMMIT.
- **COMMIT:** in_ready=0. When fbw_row_rdy=1 (guard satisfied), the FSM pulses fbw_row_swap and fbw_row_store together with bank/row addr of r.
  - If r < last: r+1, col 0, go to FILL.
  - Else: go to FLUSH.
- **FLUSH:** in_ready=0. Waits for fbw_row_rdy=1 (guard satisfied), then goes to SWAP.
- **SWAP:** when frame_rdy=1, pulses frame_swap, then goes to SWAP_WAIT.
- **SWAP_WAIT:** ignores frame_rdy for 1 cycle, then waits for frame_rdy=1. Pulses stat_frame_done and goes to SYNC.
- **Guard:** fbw_row_rdy is ignored in the cycle of a store pulse and in the cycle after it.
- **in_sof in FILL at col≠0 or r≠0:** stat_sof_err pulses. The partial row is dropped (no store) and the pixel becomes col 0 of r=0. Rows already committed remain in the back buffer and are overwritten.
- **in_sof at col 0, r=0 in FILL:** impossible by construction, since FILL is entered past col 0.
- **Counters:** col wraps at N_COLS-1 and r at N_BANKS*N_ROWS-1. There is no arithmetic beyond increment/compare.

## Timing
- All fbw_*, frame_swap and stat_* outputs are registered; in_ready is decoded from state.
- Reset values:
  - All outputs are 0.
  - in_ready is 0 while rst is high and 1 in the first cycle after release (state SYNC).
  - Counters are 0.
- Pixel accepted at cycle T appears as fbw_wren/fbw_data/fbw_col_addr at T+1.
- Last pixel of a row accepted at T: state COMMIT at T+1.
  - If fbw_row_rdy=1 at T+1, swap/store pulse at T+2 and in_ready=1 at T+2. That is one bubble per row minimum.
  - The row's last write (T+1) always precedes the swap (≥T+2).
- frame_swap is asserted the cycle after SWAP samples frame_rdy=1. stat_frame_done is asserted the cycle after SWAP_WAIT samples frame_rdy=1 (earliest 2 cycles after frame_swap).
- Reset mid-operation: immediate return to SYNC with all outputs 0. No further store or swap is issued for the partial frame.

## Test plan
All scenarios use N_BANKS=2, N_ROWS=4, N_COLS=8, N_CHANS=3, N_PLANES=8, with fbw_row_rdy and frame_rdy tied to 1 unless stated.
- **Clean frame:** stream 64 pixels, data=index, sof on first.
  - 64 writes, col 0..7 per row.
  - 8 store+swap pulses with (bank,row) = (0,0)…(0,3),(1,0)…(1,3).
  - One frame_swap, then stat_frame_done.
- **Pre-sync garbage:** 5 pixels without sof, then a clean frame. The first 5 are consumed with no fbw_wren; the rest is as in the clean-frame case.
- **Back-pressure:** hold fbw_row_rdy=0 for 10 cycles at the end of row 2.
  - in_ready stays 0 and no store is issued.
  - The store fires the cycle after rdy returns, with row_addr=2.
- **Mid-frame sof:** sof at pixel 20 (row 2, col 4).
  - stat_sof_err pulses, with no store for row 2.
  - The pixel is written at col 0, and the next store is (0,0).
- **Swap stall:** frame_rdy=0 when the last row completes.
  - No frame_swap until frame_rdy=1.
  - in_ready stays 0 until stat_frame_done, and a new sof is accepted only afterwards.
- **Async reset mid-row 3:** all outputs 0 immediately and in_ready=1 after release. A subsequent clean frame stores starting from (0,0).
